// File: rtl/core_pkg.sv
// Shared RV32I decode constants: one-hot op indices and major opcodes.
package core_pkg;
  localparam int NOPS = 37;

  localparam int OP_ADD   = 0,  OP_SUB   = 1,  OP_XOR   = 2,  OP_OR    = 3,  OP_AND  = 4;
  localparam int OP_SLL   = 5,  OP_SRL   = 6,  OP_SRA   = 7,  OP_SLT   = 8,  OP_SLTU = 9;
  localparam int OP_ADDI  = 10, OP_XORI  = 11, OP_ORI   = 12, OP_ANDI  = 13, OP_SLLI = 14;
  localparam int OP_SRLI  = 15, OP_SRAI  = 16, OP_SLTI  = 17, OP_SLTIU = 18;
  localparam int OP_LB    = 19, OP_LH    = 20, OP_LW    = 21, OP_LBU   = 22, OP_LHU  = 23;
  localparam int OP_SB    = 24, OP_SH    = 25, OP_SW    = 26;
  localparam int OP_BEQ   = 27, OP_BNE   = 28, OP_BLT   = 29, OP_BGE   = 30;
  localparam int OP_BLTU  = 31, OP_BGEU  = 32;
  localparam int OP_JAL   = 33, OP_JALR  = 34, OP_LUI   = 35, OP_AUIPC = 36;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended to 32 bits.
module imm_gen
  import core_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);
  logic [6:0] opcode;
  logic [2:0] f3;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];

  always_comb begin
    imm = '0;
    case (opcode)
      // shift immediates expose only shamt so srai does not leak funct7
      OPC_OPIMM:
        if (f3 == 3'd1 || f3 == 3'd5) imm = {27'b0, instr[24:20]};
        else                          imm = {{20{instr[31]}}, instr[31:20]};
      OPC_LOAD, OPC_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'b0};
      OPC_JAL:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:    imm = '0;
    endcase
  end
endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: one-hot decode, operand select with writeback bypass, ID/EX register.
module id_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NOPS = core_pkg::NOPS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] v1,
  output logic [XLEN-1:0] v2,
  output logic [NOPS-1:0] instructions,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic            illegal
);
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [NOPS-1:0] ops;
  logic [31:0]     imm_raw;
  logic [XLEN-1:0] imm_n, rs1_v, rs2_v, v1_n, v2_n;
  logic [4:0]      rd_n;
  logic            use_rs2, no_rd, xfer;

  assign opcode   = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  imm_gen u_imm (.instr(in_instr), .imm(imm_raw));
  assign imm_n = XLEN'(signed'(imm_raw));

  always_comb begin
    ops = '0;
    case (opcode)
      OPC_OP:
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: ops[OP_ADD]  = 1'b1;
            3'd1: ops[OP_SLL]  = 1'b1;
            3'd2: ops[OP_SLT]  = 1'b1;
            3'd3: ops[OP_SLTU] = 1'b1;
            3'd4: ops[OP_XOR]  = 1'b1;
            3'd5: ops[OP_SRL]  = 1'b1;
            3'd6: ops[OP_OR]   = 1'b1;
            default: ops[OP_AND] = 1'b1;
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'd0) ops[OP_SUB] = 1'b1;
          if (f3 == 3'd5) ops[OP_SRA] = 1'b1;
        end
      OPC_OPIMM:
        case (f3)
          3'd0: ops[OP_ADDI]  = 1'b1;
          3'd2: ops[OP_SLTI]  = 1'b1;
          3'd3: ops[OP_SLTIU] = 1'b1;
          3'd4: ops[OP_XORI]  = 1'b1;
          3'd6: ops[OP_ORI]   = 1'b1;
          3'd7: ops[OP_ANDI]  = 1'b1;
          3'd1: ops[OP_SLLI]  = (f7 == 7'h00);
          default: begin
            ops[OP_SRLI] = (f7 == 7'h00);
            ops[OP_SRAI] = (f7 == 7'h20);
          end
        endcase
      OPC_LOAD:
        case (f3)
          3'd0: ops[OP_LB]  = 1'b1;
          3'd1: ops[OP_LH]  = 1'b1;
          3'd2: ops[OP_LW]  = 1'b1;
          3'd4: ops[OP_LBU] = 1'b1;
          3'd5: ops[OP_LHU] = 1'b1;
          default: ;
        endcase
      OPC_STORE:
        case (f3)
          3'd0: ops[OP_SB] = 1'b1;
          3'd1: ops[OP_SH] = 1'b1;
          3'd2: ops[OP_SW] = 1'b1;
          default: ;
        endcase
      OPC_BRANCH:
        case (f3)
          3'd0: ops[OP_BEQ]  = 1'b1;
          3'd1: ops[OP_BNE]  = 1'b1;
          3'd4: ops[OP_BLT]  = 1'b1;
          3'd5: ops[OP_BGE]  = 1'b1;
          3'd6: ops[OP_BLTU] = 1'b1;
          3'd7: ops[OP_BGEU] = 1'b1;
          default: ;
        endcase
      OPC_JAL:   ops[OP_JAL]   = 1'b1;
      OPC_JALR:  ops[OP_JALR]  = (f3 == 3'd0);
      OPC_LUI:   ops[OP_LUI]   = 1'b1;
      OPC_AUIPC: ops[OP_AUIPC] = 1'b1;
      default: ;
    endcase
  end

  // x0 wins over both the regfile and the bypass
  assign rs1_v = (rs1_addr == 5'd0) ? '0 :
                 (wb_en && wb_rd == rs1_addr) ? wb_data : rs1_data;
  assign rs2_v = (rs2_addr == 5'd0) ? '0 :
                 (wb_en && wb_rd == rs2_addr) ? wb_data : rs2_data;

  assign use_rs2 = (|ops[OP_SLTU:OP_ADD]) || (|ops[OP_BGEU:OP_BEQ]);
  assign no_rd   = (|ops[OP_SW:OP_SB]) || (|ops[OP_BGEU:OP_BEQ]);
  assign v1_n    = ops[OP_LUI] ? '0 : (ops[OP_AUIPC] || ops[OP_JAL]) ? in_pc : rs1_v;
  assign v2_n    = use_rs2 ? rs2_v : imm_n;
  assign rd_n    = no_rd ? 5'd0 : in_instr[11:7];

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      v1           <= '0;
      v2           <= '0;
      instructions <= '0;
      rd           <= '0;
      rs2_val      <= '0;
      imm          <= '0;
      pc           <= '0;
      illegal      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid    <= 1'b1;
      v1           <= v1_n;
      v2           <= v2_n;
      instructions <= ops;
      rd           <= rd_n;
      rs2_val      <= rs2_v;
      imm          <= imm_n;
      pc           <= in_pc;
      illegal      <= ~|ops;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-encoded RV32I words with hand-computed expectations.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, wb_en, flush, out_valid, out_ready, illegal;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data, wb_data;
  logic [31:0] v1, v2, rs2_val, imm, pc;
  logic [4:0]  rs1_addr, rs2_addr, wb_rd, rd;
  logic [36:0] instructions;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .v1(v1), .v2(v2), .instructions(instructions), .rd(rd), .rs2_val(rs2_val),
    .imm(imm), .pc(pc), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; in_instr = ins; in_pc = p; rs1_data = r1; rs2_data = r2;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [36:0] oh(input int b);
    logic [36:0] r;
    r = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_instructions", instructions, 0);
    chk("rst_v1", v1, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk); rst_n = 1'b1;

    // add x3,x1,x2
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    #1;
    chk("rs1_addr", rs1_addr, 1);
    chk("rs2_addr", rs2_addr, 2);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_ops", instructions, 37'h1);
    chk("add_v1", v1, 5);
    chk("add_v2", v2, 7);
    chk("add_rd", rd, 3);

    // addi x1,x0,-1 : x0 reads 0 even with garbage on rs1_data
    drive(32'hFFF00093, 32'h4, 32'd123, 32'd0);
    tick();
    chk("addi_ops", instructions, 37'h400);
    chk("addi_v1", v1, 0);
    chk("addi_v2", v2, 32'hFFFFFFFF);

    // srai x2,x1,3
    drive(32'h4030D113, 32'h8, 32'd9, 32'd0);
    tick();
    chk("srai_ops", instructions, oh(16));
    chk("srai_v1", v1, 9);
    chk("srai_v2", v2, 3);

    // lui x5,0x12345
    drive(32'h123452B7, 32'hC, 32'd77, 32'd0);
    tick();
    chk("lui_ops", instructions, oh(35));
    chk("lui_v1", v1, 0);
    chk("lui_v2", v2, 32'h12345000);
    chk("lui_rd", rd, 5);

    // auipc x6,1 at pc 0x100
    drive(32'h00001317, 32'h100, 32'd0, 32'd0);
    tick();
    chk("auipc_ops", instructions, oh(36));
    chk("auipc_v1", v1, 32'h100);
    chk("auipc_v2", v2, 32'h1000);

    // sw x2,8(x1)
    drive(32'h0020A423, 32'h104, 32'h1000, 32'h55);
    tick();
    chk("sw_ops", instructions, oh(26));
    chk("sw_v1", v1, 32'h1000);
    chk("sw_v2", v2, 8);
    chk("sw_rd", rd, 0);
    chk("sw_rs2_val", rs2_val, 32'h55);

    // bne x1,x2,+16
    drive(32'h00209863, 32'h200, 32'h11, 32'h22);
    tick();
    chk("bne_ops", instructions, oh(28));
    chk("bne_v1", v1, 32'h11);
    chk("bne_v2", v2, 32'h22);
    chk("bne_imm", imm, 16);
    chk("bne_rd", rd, 0);

    // jal x1,+8 at pc 0x300
    drive(32'h008000EF, 32'h300, 32'h0, 32'h0);
    tick();
    chk("jal_ops", instructions, oh(33));
    chk("jal_v1", v1, 32'h300);
    chk("jal_v2", v2, 8);
    chk("jal_rd", rd, 1);

    // stall three cycles with a pending add at pc 0x400
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h400, 32'd1, 32'd2);
    #1;
    chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_ops", instructions, oh(33));
      chk("stall_pc", pc, 32'h300);
      chk("stall_in_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("unstall_ops", instructions, 37'h1);
    chk("unstall_pc", pc, 32'h400);
    chk("unstall_v2", v2, 2);

    // sub x4,x1,x1 with writeback bypass on x1
    drive(32'h40108233, 32'h404, 32'd0, 32'd0);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hAA;
    tick();
    chk("fwd_ops", instructions, oh(1));
    chk("fwd_v1", v1, 32'hAA);
    chk("fwd_v2", v2, 32'hAA);
    chk("fwd_rs2_val", rs2_val, 32'hAA);
    wb_rd = 5'd0;
    tick();
    chk("nofwd_v1", v1, 0);
    chk("nofwd_v2", v2, 0);
    wb_en = 1'b0;

    // flush with a coincident transfer
    drive(32'h002081B3, 32'h500, 32'd3, 32'd4);
    flush = 1'b1;
    tick();
    chk("flush_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_idle_valid", out_valid, 0);

    // illegal encodings
    drive(32'hFFFFFFFF, 32'h600, 32'd0, 32'd0);
    tick();
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_ops", instructions, 0);
    drive(32'h022081B3, 32'h604, 32'd1, 32'd2);
    tick();
    chk("badf7_flag", illegal, 1);
    chk("badf7_ops", instructions, 0);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    // reset during a stall drops the held op
    drive(32'h002081B3, 32'h700, 32'd9, 32'd9);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_v1", v1, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
